// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg: shared definitions for the MIPS_CPU execute stage.
//   - CMD_* decoded opcode values seen on ex_unit.op
//   - ex_state_e: state encoding of the multi-cycle multiply/divide FSM
//   - ENABLE/DISABLE flag constants
// Optional feature macro: EX_DIV_EN adds the DIV state encoding.
package ex_unit_pkg;

  localparam bit ENABLE  = 1'b1;
  localparam bit DISABLE = 1'b0;

  localparam logic [7:0] CMD_ADD   = 8'h01;
  localparam logic [7:0] CMD_ADDI  = 8'h02;
  localparam logic [7:0] CMD_SUB   = 8'h03;
  localparam logic [7:0] CMD_AND   = 8'h04;
  localparam logic [7:0] CMD_ANDI  = 8'h05;
  localparam logic [7:0] CMD_OR    = 8'h06;
  localparam logic [7:0] CMD_ORI   = 8'h07;
  localparam logic [7:0] CMD_XOR   = 8'h08;
  localparam logic [7:0] CMD_XORI  = 8'h09;
  localparam logic [7:0] CMD_SLL   = 8'h0A;
  localparam logic [7:0] CMD_SRL   = 8'h0B;
  localparam logic [7:0] CMD_SRA   = 8'h0C;
  localparam logic [7:0] CMD_LUI   = 8'h0D;
  localparam logic [7:0] CMD_MFHI  = 8'h0E;
  localparam logic [7:0] CMD_MFLO  = 8'h0F;
  localparam logic [7:0] CMD_MULT  = 8'h10;
  localparam logic [7:0] CMD_MULTU = 8'h11;
  localparam logic [7:0] CMD_DIV   = 8'h12;
  localparam logic [7:0] CMD_DIVU  = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef EX_DIV_EN
    , ST_DIV = 2'd2
`endif
  } ex_state_e;

endpackage

// File: rtl/ex_unit_muldiv.sv
// ex_muldiv: iterative multiplier (and, with EX_DIV_EN, restoring divider)
// owning the HI/LO registers of the execute stage.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       operation accepted this cycle (only sampled in IDLE)
//   op_i          CMD_MULT / CMD_MULTU (/ CMD_DIV / CMD_DIVU)
//   a_i, b_i      operands captured on start
//   done_o        high in the cycle whose edge writes HI/LO
//   busy_o        a multi-cycle operation is in progress
//   hi_o, lo_o    HI/LO register contents
// Optional feature macro: EX_DIV_EN (DIV state and divider datapath).
module ex_muldiv
  import ex_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              done_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = $clog2(DATA_W);

  ex_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic [2*DATA_W-1:0]   mcand_q, acc_q, accStep, prod;
  logic [DATA_W-1:0]     mplier_q;
  logic                  neg_q;
  logic                  isSigned, aNeg, bNeg, startMul, lastIter;
  logic [DATA_W-1:0]     aMag, bMag;
`ifdef EX_DIV_EN
  logic [DATA_W-1:0]     rem_q, quo_q, dvsr_q, dvd_q;
  logic                  dz_q, rneg_q, startDiv, remGeq;
  logic [DATA_W:0]       remWide;
  logic [DATA_W-1:0]     remNext, quoNext;
`endif

  // Operand magnitudes; the iterative datapath is unsigned and the sign
  // is reapplied on the final iteration.
  always_comb begin
    isSigned = (op_i == OP_W'(CMD_MULT));
    startMul = start_i && ((op_i == OP_W'(CMD_MULT)) || (op_i == OP_W'(CMD_MULTU)));
`ifdef EX_DIV_EN
    isSigned = isSigned || (op_i == OP_W'(CMD_DIV));
    startDiv = start_i && ((op_i == OP_W'(CMD_DIV)) || (op_i == OP_W'(CMD_DIVU)));
`endif
    aNeg     = isSigned && a_i[DATA_W-1];
    bNeg     = isSigned && b_i[DATA_W-1];
    aMag     = aNeg ? -a_i : a_i;
    bMag     = bNeg ? -b_i : b_i;
    lastIter = (cnt_q == CNT_W'(DATA_W-1));
    accStep  = acc_q + (mplier_q[0] ? mcand_q : '0);
    prod     = neg_q ? -accStep : accStep;
  end

`ifdef EX_DIV_EN
  // One restoring-division step: shift the next dividend bit into the
  // partial remainder and subtract the divisor when it fits.
  always_comb begin
    remWide = {rem_q, quo_q[DATA_W-1]};
    remGeq  = (remWide >= {1'b0, dvsr_q});
    remNext = remGeq ? DATA_W'(remWide - {1'b0, dvsr_q}) : remWide[DATA_W-1:0];
    quoNext = {quo_q[DATA_W-2:0], remGeq};
  end
`endif

  // Next-state logic; done_o flags the edge that writes HI/LO.
  always_comb begin
    state_d = state_q;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (startMul) state_d = ST_MUL;
`ifdef EX_DIV_EN
        else if (startDiv) state_d = ST_DIV;
`endif
      end
      ST_MUL: begin
        if (lastIter) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
        end
      end
`ifdef EX_DIV_EN
      ST_DIV: begin
        if (lastIter) begin
          state_d = ST_IDLE;
          done_o  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Iteration datapath, counter and HI/LO; reset aborts an operation
  // without touching HI/LO beyond clearing them.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
`ifdef EX_DIV_EN
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      dvd_q    <= '0;
      dz_q     <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q    <= '0;
            mcand_q  <= {{DATA_W{1'b0}}, aMag};
            mplier_q <= bMag;
            acc_q    <= '0;
            neg_q    <= aNeg ^ bNeg;
`ifdef EX_DIV_EN
            rem_q    <= '0;
            quo_q    <= aMag;
            dvsr_q   <= bMag;
            dvd_q    <= a_i;
            dz_q     <= (b_i == '0);
            rneg_q   <= aNeg;
`endif
          end
        end
        ST_MUL: begin
          acc_q    <= accStep;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= lastIter ? '0 : cnt_q + 1'b1;
          if (lastIter) {hi_q, lo_q} <= prod;
        end
`ifdef EX_DIV_EN
        ST_DIV: begin
          rem_q <= remNext;
          quo_q <= quoNext;
          cnt_q <= lastIter ? '0 : cnt_q + 1'b1;
          if (lastIter) begin
            hi_q <= dz_q ? dvd_q : (rneg_q ? -remNext : remNext);
            lo_q <= dz_q ? '1    : (neg_q  ? -quoNext : quoNext);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/ex_unit.sv
// ex_unit: registered execute stage of the MIPS_CPU datapath.
// Single-cycle ALU ops plus MFHI/MFLO are computed here; MULT/MULTU (and
// DIV/DIVU with EX_DIV_EN) run in ex_muldiv and stall upstream via in_ready.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   op, regaData, regbData   decoded command and operands
//   regcWr_i, regcAddr_i     destination info from decode
//   out_valid/out_ready      downstream handshake
//   regcData/regcAddr/regcWr registered result
//   busy                     multi-cycle operation in progress
// Optional feature macro: EX_DIV_EN (enables DIV/DIVU).
module ex_unit
  import ex_unit_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int OP_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_W-1:0]       op,
  input  logic [DATA_W-1:0]     regaData,
  input  logic [DATA_W-1:0]     regbData,
  input  logic                  regcWr_i,
  input  logic [REG_ADDR_W-1:0] regcAddr_i,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     regcData,
  output logic [REG_ADDR_W-1:0] regcAddr,
  output logic                  regcWr,
  output logic                  busy
);

  localparam int SH_W = $clog2(DATA_W);

  logic                  outValid_q, regcWr_q;
  logic [DATA_W-1:0]     regcData_q, result_d;
  logic [REG_ADDR_W-1:0] regcAddr_q, addr_d;
  logic                  wr_d, isMd, accept, mdDone, mdBusy;
  logic [DATA_W-1:0]     hi, lo;
  logic [SH_W-1:0]       shamt;

  assign in_ready = !mdBusy && (!outValid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = regbData[SH_W-1:0];

  ex_muldiv #(
    .DATA_W(DATA_W),
    .OP_W  (OP_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start_i(accept && isMd),
    .op_i   (op),
    .a_i    (regaData),
    .b_i    (regbData),
    .done_o (mdDone),
    .busy_o (mdBusy),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  // Single-cycle result; anything not decoded here (and not a multi-cycle
  // op) yields an all-zero beat that writes nothing.
  always_comb begin
    result_d = '0;
    wr_d     = regcWr_i;
    addr_d   = regcAddr_i;
    isMd     = (op == OP_W'(CMD_MULT)) || (op == OP_W'(CMD_MULTU));
`ifdef EX_DIV_EN
    isMd     = isMd || (op == OP_W'(CMD_DIV)) || (op == OP_W'(CMD_DIVU));
`endif
    case (op)
      OP_W'(CMD_ADD), OP_W'(CMD_ADDI): result_d = regaData + regbData;
      OP_W'(CMD_SUB):                  result_d = regaData - regbData;
      OP_W'(CMD_AND), OP_W'(CMD_ANDI): result_d = regaData & regbData;
      OP_W'(CMD_OR),  OP_W'(CMD_ORI):  result_d = regaData | regbData;
      OP_W'(CMD_XOR), OP_W'(CMD_XORI): result_d = regaData ^ regbData;
      OP_W'(CMD_SLL):                  result_d = regaData << shamt;
      OP_W'(CMD_SRL):                  result_d = regaData >> shamt;
      OP_W'(CMD_SRA):                  result_d = $unsigned($signed(regaData) >>> shamt);
      OP_W'(CMD_LUI):                  result_d = regaData << (DATA_W/2);
      OP_W'(CMD_MFHI):                 result_d = hi;
      OP_W'(CMD_MFLO):                 result_d = lo;
      default: begin
        wr_d   = 1'b0;
        addr_d = '0;
      end
    endcase
  end

  // Output register. A multi-cycle completion cannot collide with a new
  // accept because in_ready is low while the unit is busy; a consume and
  // accept on the same edge simply overwrites the held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      regcData_q <= '0;
      regcAddr_q <= '0;
      regcWr_q   <= 1'b0;
    end else if (mdDone) begin
      outValid_q <= 1'b1;
      regcData_q <= '0;
      regcAddr_q <= '0;
      regcWr_q   <= 1'b0;
    end else if (accept && !isMd) begin
      outValid_q <= 1'b1;
      regcData_q <= result_d;
      regcAddr_q <= addr_d;
      regcWr_q   <= wr_d;
    end else if (out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign out_valid = outValid_q;
  assign regcData  = regcData_q;
  assign regcAddr  = regcAddr_q;
  assign regcWr    = regcWr_q;
  assign busy      = mdBusy;

endmodule

// File: doc/ex_unit.md
# ex_unit

Parametrised, registered execute stage for the MIPS_CPU datapath. It sits between the decode stage and the memory stage. It performs single-cycle ALU operations, plus an iterative multiplier (and optionally a divider) writing internal HI/LO registers. A valid/ready handshake on both sides lets the unit stall the upstream while a multi-cycle operation is in progress.

## Interface
- DATA_W, 32: datapath width (power of two, ≥8)
- REG_ADDR_W, 5: register-address width
- OP_W, 8: width of decoded opcode (CMD_* codes)
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- in_valid  in  1  decode presents an operation
- in_ready  out  1  unit accepts an operation this cycle
- op  in  OP_W  decoded command (CMD_*)
- regaData  in  DATA_W  operand A
- regbData  in  DATA_W  operand B / immediate / shift amount
- regcWr_i  in  1  destination write enable from decode
- regcAddr_i  in  REG_ADDR_W  destination register number
- out_valid  out  1  result register holds a valid result
- out_ready  in  1  downstream consumes result
- regcData  out  DATA_W  result
- regcAddr  out  REG_ADDR_W  destination address
- regcWr  out  1  destination write enable
- busy  out  1  multi-cycle operation in progress

## Operation
- Accept on in_valid && in_ready. in_ready = !busy && (!out_valid || out_ready).
- Single-cycle ops: ADD/ADDI (wrap, no overflow trap), SUB, AND/ANDI, OR/ORI, XOR/XORI, SLL, SRL, SRA, LUI.
  - Shift amount = regbData[log2(DATA_W)-1:0]. SRA is true arithmetic shift (sign fill).
  - LUI = regaData << (DATA_W/2).
  - regcWr/regcAddr pass through from regcWr_i/regcAddr_i.
- MFHI/MFLO: regcData = HI/LO, single-cycle.
- MULT/MULTU: unsigned shift-add over the operand magnitudes. Signed result is negated at the end. {HI,LO} = 2·DATA_W-bit product. The result beat has regcWr=0 and regcAddr=0.
- Unknown op: result beat with regcData=0, regcWr=0, regcAddr=0.
- FSM states: IDLE, MUL, DIV (DIV only with EX_DIV_EN).
  - IDLE→MUL on accepting MULT/MULTU. Counter is loaded with 0.
  - MUL→IDLE when the counter reaches DATA_W-1. HI/LO are written and out_valid is set on that edge.
  - busy=1 in MUL/DIV.
- Back-to-back: MFHI accepted in the cycle after MULT completion sees the new HI.

## Timing
- Reset values: out_valid=0, regcData=0, regcAddr=0, regcWr=0, busy=0, HI=LO=0, FSM=IDLE, counter=0. in_ready becomes 1 in the first cycle after rst deasserts.
- Single-cycle op: accepted at edge N, out_valid=1 with its result after edge N.
- MULT/MULTU: accepted at edge N; busy=1 from N to N+DATA_W-1; result beat valid after edge N+DATA_W.
- Output hold: while out_valid && !out_ready, regcData/regcAddr/regcWr are held stable and in_ready=0.
- Simultaneous consume and accept (out_ready=1, in_valid=1, IDLE): the new result replaces the old one on the same edge with no bubble.
- out_valid drops on consume when there is no new result.
- rst mid-operation: the multi-cycle op is aborted, with no HI/LO update and no result beat. All outputs return to their reset values on that edge.

## Configuration
- EX_DIV_EN defined:
  - DIV/DIVU are supported via a restoring divider, DATA_W iterations, same latency and handshake as MULT. LO=quotient, HI=remainder, signed per MIPS (remainder takes the dividend's sign).
  - Divide by zero: LO=all ones, HI=dividend, completes in normal latency.
- EX_DIV_EN undefined: DIV/DIVU are treated as unknown ops (zero result, regcWr=0). The DIV state and divider logic are absent.

## Structure
- Shared package/header MIPS.vh holds the CMD_* codes (CMD_MULT, CMD_MULTU, CMD_MFHI, CMD_MFLO, CMD_DIV, CMD_DIVU added), FSM state encodings, and ENABLE/DISABLE.
- One sub-module, ex_muldiv, contains the FSM, counter, HI/LO and iterative datapath. Its interface is start/op/a/b in and done/hi/lo out.
- The single-cycle ALU and the output register stay in ex_unit.

## Test plan
- DATA_W=32: ADD 0x7FFFFFFF+1 → regcData=0x80000000, regcWr/regcAddr from inputs, out_valid one cycle after accept.
- SRA 0x80000000 by regbData=0x24 (amount 4) → 0xF8000000. SRL same operands → 0x08000000.
- MULT 0xFFFFFFFE×3 (signed -2×3) → busy for 32 cycles, then beat with regcWr=0. MFHI → 0xFFFFFFFF, MFLO → 0xFFFFFFFA. MULTU same operands → HI=0x00000002.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 → outputs stable, in_ready=0, no op lost. Then one cycle of out_ready=1 consumes the result and accepts the next op on the same edge.
- Assert rst at cycle 10 of a MULT → no result beat, HI=LO=0, out_valid=0. in_ready=1 in the first cycle after rst deasserts.
- EX_DIV_EN: DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 5/0 → LO=0xFFFFFFFF, HI=5. Without the macro, DIV gives regcWr=0, regcData=0.
